// File: rtl/serv_rf_sram_if.sv
// Bridge between SERV's bit-serial two-read/two-write register port and a
// single-port word-wide RF RAM, using fixed time slots so RAM reads and writes never overlap.
module serv_rf_sram_if #(
  parameter int width    = 8,
  parameter int csr_regs = 4,
  parameter int depth    = 32*(32+csr_regs)/width,
  localparam int aw  = $clog2(depth),
  localparam int rw  = $clog2(32+csr_regs),
  localparam int l2w = $clog2(width)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rreq,
  input  logic [rw-1:0]    i_rreg0,
  input  logic [rw-1:0]    i_rreg1,
  input  logic             i_wen0,
  input  logic             i_wen1,
  input  logic [rw-1:0]    i_wreg0,
  input  logic [rw-1:0]    i_wreg1,
  input  logic             i_wdata0,
  input  logic             i_wdata1,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_rdata0,
  output logic             o_rdata1,
  output logic [aw-1:0]    o_waddr,
  output logic [width-1:0] o_wdata,
  output logic             o_wen,
  output logic [aw-1:0]    o_raddr,
  input  logic [width-1:0] i_rdata
);

  // state | meaning
  // IDLE  | waiting for i_rreq
  // PRE   | fetch first rs1/rs2 words (cnt 2..0), o_ready on the last cycle
  // RUN   | 32 serial bit cycles (cnt 31..0), slot-scheduled reads/writes
  // FLUSH | write back the last chunk of port 0 (cnt 1) and port 1 (cnt 0)
  typedef enum logic [1:0] {IDLE, PRE, RUN, FLUSH} state_t;

  localparam logic [4:0] LAST_K = 5'(31/width);
  localparam logic [4:0] S_MAX  = 5'(width-1);

  function automatic logic [aw-1:0] word_addr(input logic [rw-1:0] r, input logic [4:0] k);
    logic [31:0] t;
    t = (32'(r) << (5 - l2w)) + 32'(k);
    return t[aw-1:0];
  endfunction

  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [rw-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic [rw-1:0] wreg0_q, wreg0_d, wreg1_q, wreg1_d;
  logic wen0_q, wen0_d, wen1_q, wen1_d;
  logic [aw-1:0] raddr_q, raddr_d;
  logic [width-1:0] stg0_q, stg0_d, stg1_q, stg1_d;
  logic [width-1:0] sh0_q, sh0_d, sh1_q, sh1_d;
  logic [width-1:0] pk0_q, pk0_d, pk1_q, pk1_d;
  logic [width-1:0] wd0_q, wd0_d, wd1_q, wd1_d;
  logic rst_dly_q, rst_dly_d;

  logic [4:0] bit_idx, slot, chunk;
  logic [aw-1:0] rd_addr, waddr;
  logic [width-1:0] wdata;
  logic wen, ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    wreg0_d   = wreg0_q;
    wreg1_d   = wreg1_q;
    wen0_d    = wen0_q;
    wen1_d    = wen1_q;
    stg0_d    = stg0_q;
    stg1_d    = stg1_q;
    sh0_d     = sh0_q;
    sh1_d     = sh1_q;
    pk0_d     = pk0_q;
    pk1_d     = pk1_q;
    wd0_d     = wd0_q;
    wd1_d     = wd1_q;
    rst_dly_d = 1'b0;
    rd_addr   = raddr_q;
    wen       = 1'b0;
    waddr     = '0;
    wdata     = '0;
    ready     = 1'b0;
    bit_idx   = ~cnt_q;
    slot      = bit_idx & S_MAX;
    chunk     = bit_idx >> l2w;

    case (state_q)
      IDLE: begin
        // the first cycle out of reset still has rst_dly_q set, so a request there is dropped
        if (i_rreq && !rst_dly_q) begin
          state_d = PRE;
          cnt_d   = 5'd2;
          rs1_d   = i_rreg0;
          rs2_d   = i_rreg1;
          wreg0_d = i_wreg0;
          wreg1_d = i_wreg1;
          wen0_d  = i_wen0;
          wen1_d  = i_wen1;
        end
      end
      PRE: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd2) begin
          rd_addr = word_addr(rs1_q, 5'd0);
        end else if (cnt_q == 5'd1) begin
          rd_addr = word_addr(rs2_q, 5'd0);
          stg0_d  = i_rdata;
        end else begin
          sh0_d   = stg0_q;
          sh1_d   = i_rdata;
          ready   = 1'b1;
          state_d = RUN;
          cnt_d   = 5'd31;
        end
      end
      RUN: begin
        cnt_d = cnt_q - 5'd1;
        sh0_d = sh0_q >> 1;
        sh1_d = sh1_q >> 1;
        pk0_d = {i_wdata0, pk0_q[width-1:1]};
        pk1_d = {i_wdata1, pk1_q[width-1:1]};
        if (slot == S_MAX) begin
          wd0_d = pk0_d;
          wd1_d = pk1_d;
        end
        if (chunk != LAST_K) begin
          if (slot == 5'd2) rd_addr = word_addr(rs1_q, chunk + 5'd1);
          if (slot == 5'd3) begin
            rd_addr = word_addr(rs2_q, chunk + 5'd1);
            stg0_d  = i_rdata;
          end
          if (slot == 5'd4) stg1_d = i_rdata;
          if (slot == S_MAX) begin
            sh0_d = stg0_q;
            sh1_d = stg1_q;
          end
        end
        if (chunk != 5'd0) begin
          if (slot == 5'd0 && wen0_q) begin
            wen   = 1'b1;
            waddr = word_addr(wreg0_q, chunk - 5'd1);
            wdata = wd0_q;
          end
          if (slot == 5'd1 && wen1_q) begin
            wen   = 1'b1;
            waddr = word_addr(wreg1_q, chunk - 5'd1);
            wdata = wd1_q;
          end
        end
        if (cnt_q == 5'd0) begin
          state_d = FLUSH;
          cnt_d   = 5'd1;
        end
      end
      FLUSH: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          if (wen0_q) begin
            wen   = 1'b1;
            waddr = word_addr(wreg0_q, LAST_K);
            wdata = wd0_q;
          end
        end else begin
          if (wen1_q) begin
            wen   = 1'b1;
            waddr = word_addr(wreg1_q, LAST_K);
            wdata = wd1_q;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    raddr_d = rd_addr;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      wreg0_q   <= '0;
      wreg1_q   <= '0;
      wen0_q    <= 1'b0;
      wen1_q    <= 1'b0;
      raddr_q   <= '0;
      stg0_q    <= '0;
      stg1_q    <= '0;
      sh0_q     <= '0;
      sh1_q     <= '0;
      pk0_q     <= '0;
      pk1_q     <= '0;
      wd0_q     <= '0;
      wd1_q     <= '0;
      rst_dly_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      wreg0_q   <= wreg0_d;
      wreg1_q   <= wreg1_d;
      wen0_q    <= wen0_d;
      wen1_q    <= wen1_d;
      raddr_q   <= raddr_d;
      stg0_q    <= stg0_d;
      stg1_q    <= stg1_d;
      sh0_q     <= sh0_d;
      sh1_q     <= sh1_d;
      pk0_q     <= pk0_d;
      pk1_q     <= pk1_d;
      wd0_q     <= wd0_d;
      wd1_q     <= wd1_d;
      rst_dly_q <= rst_dly_d;
    end
  end

  // a write slot that coincides with reset is dropped rather than committed
  assign o_wen    = wen & ~i_rst;
  assign o_waddr  = waddr;
  assign o_wdata  = wdata;
  assign o_ready  = ready & ~i_rst;
  assign o_raddr  = rd_addr;
  assign o_busy   = (state_q != IDLE);
  assign o_rdata0 = (state_q == RUN) & sh0_q[0];
  assign o_rdata1 = (state_q == RUN) & sh1_q[0];

endmodule

// File: tb/tb_serv_rf_sram_if.sv
// Scoreboard bench for serv_rf_sram_if: width-8 and width-32 instances, each with a
// registered RAM model; expected writes/reads are queued by stimulus and popped by monitors.
module tb_serv_rf_sram_if;

  typedef struct { int cyc; logic [31:0] addr; logic [31:0] data; } wexp_t;
  typedef struct { int cyc; logic [31:0] d0; logic [31:0] d1; } rexp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rreq8, rreq32, wen0, wen1, wdat0, wdat1, init_ram;
  logic [5:0] rreg0, rreg1, wreg0, wreg1;

  logic ready8, busy8, rd0_8, rd1_8, wen8;
  logic [7:0] waddr8, wdata8, raddr8, rdata8;
  logic ready32, busy32, rd0_32, rd1_32, wen32;
  logic [5:0] waddr32, raddr32;
  logic [31:0] wdata32, rdata32;

  serv_rf_sram_if u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_rreq(rreq8), .i_rreg0(rreg0), .i_rreg1(rreg1),
    .i_wen0(wen0), .i_wen1(wen1), .i_wreg0(wreg0), .i_wreg1(wreg1),
    .i_wdata0(wdat0), .i_wdata1(wdat1), .o_ready(ready8), .o_busy(busy8),
    .o_rdata0(rd0_8), .o_rdata1(rd1_8), .o_waddr(waddr8), .o_wdata(wdata8),
    .o_wen(wen8), .o_raddr(raddr8), .i_rdata(rdata8));

  serv_rf_sram_if #(.width(32), .csr_regs(4)) u_dut32 (
    .i_clk(clk), .i_rst(rst), .i_rreq(rreq32), .i_rreg0(rreg0), .i_rreg1(rreg1),
    .i_wen0(wen0), .i_wen1(wen1), .i_wreg0(wreg0), .i_wreg1(wreg1),
    .i_wdata0(wdat0), .i_wdata1(wdat1), .o_ready(ready32), .o_busy(busy32),
    .o_rdata0(rd0_32), .o_rdata1(rd1_32), .o_waddr(waddr32), .o_wdata(wdata32),
    .o_wen(wen32), .o_raddr(raddr32), .i_rdata(rdata32));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  mem8  [0:143];
  logic [31:0] mem32 [0:35];

  always @(posedge clk) begin
    if (init_ram) begin
      for (int a = 0; a < 144; a++)
        mem8[a] <= (a >= 20 && a < 24) ? 8'(16 + a - 20) :
                   (a >= 24 && a < 28) ? 8'(32 + a - 24) : 8'h00;
    end else begin
      if (wen8) mem8[waddr8] <= wdata8;
      rdata8 <= mem8[raddr8];
    end
  end

  always @(posedge clk) begin
    if (init_ram) begin
      for (int a = 0; a < 36; a++)
        mem32[a] <= (a == 33) ? 32'h89ABCDEF : (a == 2) ? 32'h00C0FFEE : 32'h0;
    end else begin
      if (wen32) mem32[waddr32] <= wdata32;
      rdata32 <= mem32[raddr32];
    end
  end

  wexp_t wq8[$], wq32[$];
  rexp_t rq8[$], rq32[$];

  bit col8 = 1'b0, col32 = 1'b0;
  int nb8 = 0, nb32 = 0;
  logic [31:0] s0_8, s1_8, s0_32, s1_32;
  rexp_t cur8, cur32;

  always @(negedge clk) begin
    wexp_t we;
    if (wen8) begin
      if (wq8.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write_w8 actual=addr %h data %h at cyc %0d required=no write", waddr8, wdata8, cyc);
      end else begin
        we = wq8.pop_front();
        chk("write_cyc_w8", 32'(cyc), 32'(we.cyc));
        chk("write_addr_w8", {24'b0, waddr8}, we.addr);
        chk("write_data_w8", {24'b0, wdata8}, we.data);
      end
    end
    if (rst) col8 = 1'b0;
    else begin
      if (col8) begin
        s0_8 = {rd0_8, s0_8[31:1]};
        s1_8 = {rd1_8, s1_8[31:1]};
        nb8++;
        if (nb8 == 32) begin
          chk("rdata0_w8", s0_8, cur8.d0);
          chk("rdata1_w8", s1_8, cur8.d1);
          col8 = 1'b0;
        end
      end
      if (ready8) begin
        if (rq8.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ready_w8 actual=ready at cyc %0d required=no ready", cyc);
        end else begin
          cur8 = rq8.pop_front();
          chk("ready_cyc_w8", 32'(cyc), 32'(cur8.cyc));
          col8 = 1'b1;
          nb8 = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    wexp_t we;
    if (wen32) begin
      if (wq32.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write_w32 actual=addr %h data %h at cyc %0d required=no write", waddr32, wdata32, cyc);
      end else begin
        we = wq32.pop_front();
        chk("write_cyc_w32", 32'(cyc), 32'(we.cyc));
        chk("write_addr_w32", {26'b0, waddr32}, we.addr);
        chk("write_data_w32", wdata32, we.data);
      end
    end
    if (rst) col32 = 1'b0;
    else begin
      if (col32) begin
        s0_32 = {rd0_32, s0_32[31:1]};
        s1_32 = {rd1_32, s1_32[31:1]};
        nb32++;
        if (nb32 == 32) begin
          chk("rdata0_w32", s0_32, cur32.d0);
          chk("rdata1_w32", s1_32, cur32.d1);
          col32 = 1'b0;
        end
      end
      if (ready32) begin
        if (rq32.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ready_w32 actual=ready at cyc %0d required=no ready", cyc);
        end else begin
          cur32 = rq32.pop_front();
          chk("ready_cyc_w32", 32'(cyc), 32'(cur32.cyc));
          col32 = 1'b1;
          nb32 = 0;
        end
      end
    end
  end

  // One transaction: queue expectations, issue i_rreq, then drive 32 serial write bits.
  task automatic txn(input bit big, input logic [5:0] r0, input logic [5:0] r1,
                     input bit we0, input bit we1, input logic [5:0] w0, input logic [5:0] w1,
                     input logic [31:0] d0, input logic [31:0] d1,
                     input logic [31:0] exp0, input logic [31:0] exp1,
                     input int pulse_at, input int rst_at);
    int t0, n, wd, c0;
    logic [31:0] mask;
    rexp_t re;
    wexp_t we;
    bit aborted;
    wd = big ? 32 : 8;
    n = 32 / wd;
    mask = big ? 32'hFFFFFFFF : 32'h000000FF;
    t0 = cyc;
    re.cyc = t0 + 3; re.d0 = exp0; re.d1 = exp1;
    if (big) rq32.push_back(re); else rq8.push_back(re);
    for (int k = 0; k < n; k++) begin
      c0 = (k < n - 1) ? t0 + 4 + wd * (k + 1) : t0 + 36;
      if (we0 && (rst_at < 0 || c0 < t0 + rst_at)) begin
        we.cyc = c0; we.addr = 32'(w0) * 32'(n) + 32'(k); we.data = (d0 >> (wd * k)) & mask;
        if (big) wq32.push_back(we); else wq8.push_back(we);
      end
      if (we1 && (rst_at < 0 || c0 + 1 < t0 + rst_at)) begin
        we.cyc = c0 + 1; we.addr = 32'(w1) * 32'(n) + 32'(k); we.data = (d1 >> (wd * k)) & mask;
        if (big) wq32.push_back(we); else wq8.push_back(we);
      end
    end
    rreg0 = r0; rreg1 = r1; wen0 = we0; wen1 = we1; wreg0 = w0; wreg1 = w1;
    if (big) rreq32 = 1'b1; else rreq8 = 1'b1;
    tick();
    rreq8 = 1'b0; rreq32 = 1'b0;
    repeat (3) tick();
    aborted = 1'b0;
    for (int i = 0; i < 32 && !aborted; i++) begin
      wdat0 = d0[i];
      wdat1 = d1[i];
      if (big && 4 + i == 20) chk("raddr_hold_w32", {26'b0, raddr32}, {26'b0, r1});
      if (4 + i == pulse_at) begin
        rreg0 = 6'd1; rreg1 = 6'd2; wen0 = 1'b1; wreg0 = 6'd30;
        if (big) rreq32 = 1'b1; else rreq8 = 1'b1;
      end
      if (4 + i == rst_at) rst = 1'b1;
      tick();
      rreq8 = 1'b0; rreq32 = 1'b0;
      if (rst) begin
        rst = 1'b0;
        aborted = 1'b1;
        chk("busy_after_rst", {31'b0, big ? busy32 : busy8}, 32'd0);
        chk("wen_after_rst", {31'b0, big ? wen32 : wen8}, 32'd0);
        chk("ready_after_rst", {31'b0, big ? ready32 : ready8}, 32'd0);
      end
    end
    if (aborted) repeat (3) tick();
    else begin
      tick();
      chk("busy_cyc37", {31'b0, big ? busy32 : busy8}, 32'd1);
      tick();
      chk("busy_cyc38", {31'b0, big ? busy32 : busy8}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; init_ram = 1'b1; rreq8 = 1'b0; rreq32 = 1'b0;
    wen0 = 1'b0; wen1 = 1'b0; wdat0 = 1'b0; wdat1 = 1'b0;
    rreg0 = '0; rreg1 = '0; wreg0 = '0; wreg1 = '0;
    repeat (2) tick();
    init_ram = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", {31'b0, busy8}, 32'd0);
    chk("rst_ready", {31'b0, ready8}, 32'd0);
    chk("rst_wen", {31'b0, wen8}, 32'd0);
    chk("rst_rdata0", {31'b0, rd0_8}, 32'd0);
    chk("rst_rdata1", {31'b0, rd1_8}, 32'd0);
    chk("rst_raddr", {24'b0, raddr8}, 32'd0);
    chk("rst_waddr", {24'b0, waddr8}, 32'd0);
    chk("rst_wdata", {24'b0, wdata8}, 32'd0);
    chk("rst_busy_w32", {31'b0, busy32}, 32'd0);
    tick();

    // plain read of x5/x6
    txn(1'b0, 6'd5, 6'd6, 1'b0, 1'b0, 6'd0, 6'd0, 32'h0, 32'h0,
        32'h13121110, 32'h23222120, -1, -1);
    // port 0 writes 0xDEADBEEF to x7
    txn(1'b0, 6'd5, 6'd6, 1'b1, 1'b0, 6'd7, 6'd0, 32'hDEADBEEF, 32'h0,
        32'h13121110, 32'h23222120, -1, -1);
    // both ports write; read back x7
    txn(1'b0, 6'd7, 6'd5, 1'b1, 1'b1, 6'd3, 6'd4, 32'h01234567, 32'h89ABCDEF,
        32'hDEADBEEF, 32'h13121110, -1, -1);
    // same wreg on both ports, spurious rreq during RUN
    txn(1'b0, 6'd3, 6'd4, 1'b1, 1'b1, 6'd9, 6'd9, 32'h11111111, 32'h22222222,
        32'h01234567, 32'h89ABCDEF, 10, -1);
    // back-to-back at first IDLE: port 1 must have won on x9
    txn(1'b0, 6'd9, 6'd3, 1'b0, 1'b0, 6'd0, 6'd0, 32'h0, 32'h0,
        32'h22222222, 32'h01234567, -1, -1);
    // reset at cycle 20: only the chunk-0 write of x10 survives
    txn(1'b0, 6'd1, 6'd2, 1'b1, 1'b0, 6'd10, 6'd0, 32'hCAFEF00D, 32'h0,
        32'h0, 32'h0, -1, 20);
    txn(1'b0, 6'd10, 6'd5, 1'b0, 1'b0, 6'd0, 6'd0, 32'h0, 32'h0,
        32'h0000000D, 32'h13121110, -1, -1);
    // width 32: CSR reg 33, flush-only writes, then read back
    txn(1'b1, 6'd33, 6'd2, 1'b1, 1'b1, 6'd20, 6'd21, 32'h12345678, 32'h9ABCDEF0,
        32'h89ABCDEF, 32'h00C0FFEE, -1, -1);
    txn(1'b1, 6'd20, 6'd21, 1'b0, 1'b0, 6'd0, 6'd0, 32'h0, 32'h0,
        32'h12345678, 32'h9ABCDEF0, -1, -1);

    repeat (4) tick();
    chk("pending_writes_w8", 32'(wq8.size()), 32'd0);
    chk("pending_reads_w8", 32'(rq8.size()) + {31'b0, col8}, 32'd0);
    chk("pending_writes_w32", 32'(wq32.size()), 32'd0);
    chk("pending_reads_w32", 32'(rq32.size()) + {31'b0, col32}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
